// File: rtl/flasher_flick_arbiter.sv
// Round-robin owner arbitration for a single shared flasher. Issues one flick per grant,
// tracks the flasher until it is idle and dark, and aborts stalled runs with an err pulse.
module flasher_flick_arbiter #(
  parameter int         NREQ       = 4,
  parameter logic [3:0] IDLE_STATE = 4'd0,
  parameter int         START_WAIT = 4,
  parameter int         TIMEOUT    = 127
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      fl_state,
  input  logic [15:0]     fl_out,
  output logic            flick,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(START_WAIT + 1);
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] START_LAST = SW'(START_WAIT - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_REQ   = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLICK,
    S_WAIT_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   ptr, ptr_next;
  logic [IW-1:0]   owner, owner_next, owner_inc;
  logic [SW-1:0]   start_cnt, start_cnt_next;
  logic [RW-1:0]   run_cnt, run_cnt_next;
  logic [NREQ-1:0] grant_next, done_next;
  logic            flick_next, err_next, busy_next;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     cand;
  logic            fl_finished;

  assign owner_inc   = (owner == LAST_REQ) ? '0 : owner + IW'(1);
  assign fl_finished = (fl_state == IDLE_STATE) && (fl_out == 16'h0000);

  // First requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!pick_found && req[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    owner_next     = owner;
    start_cnt_next = start_cnt;
    run_cnt_next   = run_cnt;
    grant_next     = grant;
    done_next      = '0;
    flick_next     = 1'b0;
    err_next       = 1'b0;

    case (state)
      S_IDLE: begin
        grant_next = '0;
        if (pick_found) begin
          state_next = S_FLICK;
          owner_next = pick_idx;
          grant_next = NREQ'(1) << pick_idx;
          flick_next = 1'b1;
        end
      end

      S_FLICK: begin
        state_next     = S_WAIT_START;
        start_cnt_next = '0;
      end

      S_WAIT_START: begin
        if (fl_state != IDLE_STATE) begin
          state_next   = S_RUN;
          run_cnt_next = '0;
        end else if (start_cnt >= START_LAST) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
          grant_next = '0;
          ptr_next   = owner_inc;
        end else begin
          start_cnt_next = start_cnt + SW'(1);
        end
      end

      S_RUN: begin
        if (fl_finished) begin
          state_next = S_DONE;
          done_next  = grant;
        end else if (run_cnt >= RUN_LAST) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
          grant_next = '0;
          ptr_next   = owner_inc;
        end else if (run_cnt != RUN_MAX) begin
          run_cnt_next = run_cnt + RW'(1);
        end
      end

      S_DONE: begin
        // Pointer advances past the owner even on the normal path so it cannot re-win immediately.
        state_next = S_IDLE;
        grant_next = '0;
        ptr_next   = owner_inc;
      end

      default: begin
        state_next = S_IDLE;
        grant_next = '0;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      owner     <= '0;
      start_cnt <= '0;
      run_cnt   <= '0;
      flick     <= 1'b0;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      owner     <= owner_next;
      start_cnt <= start_cnt_next;
      run_cnt   <= run_cnt_next;
      flick     <= flick_next;
      grant     <= grant_next;
      done      <= done_next;
      err       <= err_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_flasher_flick_arbiter.sv
// Directed bench for flasher_flick_arbiter: the flasher is driven step by step from one initial block.
module tb_flasher_flick_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  fl_state;
  logic [15:0] fl_out;
  logic        flick;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int flick_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  flasher_flick_arbiter #(
    .NREQ(4), .IDLE_STATE(4'd0), .START_WAIT(4), .TIMEOUT(127)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .fl_state(fl_state), .fl_out(fl_out),
    .flick(flick), .grant(grant), .done(done), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (err) err_cnt++;
    if (flick) flick_cnt++;
    if (|done) done_cnt++;
    if (err && (|done)) overlap_cnt++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with req already applied; runs one full grant lasting run_len RUN cycles.
  task automatic serve(input string tag, input logic [3:0] exp_grant, input int run_len);
    int fc0;
    fc0 = flick_cnt;
    tick();
    chk({tag, " grant@flick"}, 32'(grant), 32'(exp_grant));
    chk({tag, " flick"}, 32'(flick), 32'd1);
    tick();
    chk({tag, " flick one cycle"}, 32'(flick), 32'd0);
    fl_state = 4'd1;
    fl_out   = 16'hA5A5;
    tick();
    chk({tag, " busy in run"}, 32'(busy), 32'd1);
    repeat (run_len - 1) tick();
    fl_state = 4'd0;
    fl_out   = 16'h0000;
    tick();
    chk({tag, " done"}, 32'(done), 32'(exp_grant));
    chk({tag, " grant@done"}, 32'(grant), 32'(exp_grant));
    tick();
    chk({tag, " grant free"}, 32'(grant), 32'd0);
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " flicks per grant"}, 32'(flick_cnt - fc0), 32'd1);
  endtask

  initial begin
    int d0;
    reset    = 1'b0;
    req      = 4'b0000;
    fl_state = 4'd0;
    fl_out   = 16'h0000;
    repeat (3) tick();
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst flick", 32'(flick), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle no req busy", 32'(busy), 32'd0);

    // Single requester, 60-cycle flasher run.
    req = 4'b0001;
    serve("t1", 4'b0001, 60);
    req = 4'b0000;
    tick();
    chk("t1 stays free", 32'(grant), 32'd0);
    chk("t1 no err", 32'(err_cnt), 32'd0);

    // Async reset in the middle of a run; pointer was 1 before it.
    req = 4'b0010;
    tick();
    chk("t5 grant", 32'(grant), 32'b0010);
    tick();
    fl_state = 4'd1;
    fl_out   = 16'h00F0;
    tick();
    repeat (5) tick();
    chk("t5 busy pre-reset", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5 async grant", 32'(grant), 32'd0);
    chk("t5 async flick", 32'(flick), 32'd0);
    chk("t5 async busy", 32'(busy), 32'd0);
    fl_state = 4'd0;
    fl_out   = 16'h0000;
    req      = 4'b1111;
    @(posedge clk);
    #1 reset = 1'b1;

    // Round robin from a reset pointer.
    serve("rr0", 4'b0001, 3);
    serve("rr1", 4'b0010, 3);
    serve("rr2", 4'b0100, 3);
    serve("rr3", 4'b1000, 3);
    serve("rr4", 4'b0001, 3);

    // Start watchdog: flasher ignores the flick.
    tick();
    chk("t3 grant", 32'(grant), 32'b0010);
    tick();
    repeat (3) tick();
    chk("t3 no err at 3", 32'(err), 32'd0);
    chk("t3 busy at 3", 32'(busy), 32'd1);
    tick();
    chk("t3 err", 32'(err), 32'd1);
    chk("t3 grant cleared", 32'(grant), 32'd0);
    chk("t3 busy cleared", 32'(busy), 32'd0);
    tick();
    chk("t3 err one cycle", 32'(err), 32'd0);
    chk("t3 next owner", 32'(grant), 32'b0100);

    // Run watchdog: flasher goes to idle state but lamps stay lit.
    d0 = done_cnt;
    tick();
    fl_state = 4'd2;
    fl_out   = 16'h0001;
    tick();
    fl_state = 4'd0;
    repeat (126) tick();
    chk("t4 no err at 126", 32'(err), 32'd0);
    chk("t4 busy at 126", 32'(busy), 32'd1);
    tick();
    chk("t4 err", 32'(err), 32'd1);
    chk("t4 busy dropped", 32'(busy), 32'd0);
    chk("t4 grant cleared", 32'(grant), 32'd0);
    req    = 4'b0000;
    fl_out = 16'h0000;
    tick();
    chk("t4 err one cycle", 32'(err), 32'd0);
    chk("t4 no done", 32'(done_cnt - d0), 32'd0);

    // Withdrawal after grant plus a new request mid-run; pointer is 3.
    req = 4'b0010;
    tick();
    chk("t6 grant", 32'(grant), 32'b0010);
    req = 4'b0000;
    tick();
    fl_state = 4'd1;
    fl_out   = 16'h0004;
    tick();
    req = 4'b0001;
    repeat (10) tick();
    chk("t6 grant held", 32'(grant), 32'b0010);
    fl_state = 4'd0;
    tick();
    chk("t6 lamps on no done", 32'(done), 32'd0);
    fl_out = 16'h0000;
    tick();
    chk("t6 done", 32'(done), 32'b0010);
    chk("t6 grant@done", 32'(grant), 32'b0010);
    tick();
    chk("t6 free cycle", 32'(grant), 32'd0);
    serve("t6b", 4'b0001, 2);
    req = 4'b0000;
    tick();

    chk("total err pulses", 32'(err_cnt), 32'd2);
    chk("err/done overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
